// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the slice-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  // Number of slices (cycles) needed to cover the full operand width.
  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // Slice counter width; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_slice.sv
// Combinational W-bit ripple-borrow subtractor: d = a - b - bin.
module sub_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  logic [W:0] br;

  assign br[0] = bin;

  // One full subtractor per bit; the borrow ripples LSB to MSB.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_fs
      assign d[gi]    = a[gi] ^ b[gi] ^ br[gi];
      assign br[gi+1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & br[gi]);
    end
  endgenerate

  assign bout = br[W];

endmodule

// File: rtl/serial_subtractor.sv
// Slice-serial subtractor: x - y - bin computed SLICE bits per cycle,
// with registered difference, borrow-out and signed-overflow flags.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int CW     = cnt_width(NSLICE);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);
  localparam int MSB    = WIDTH - 1;

  // Reject configurations where the slices do not tile the operand exactly.
  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_width
      $error("serial_subtractor: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_reg;
  logic [WIDTH-1:0] work_reg;
  logic [WIDTH-1:0] work_next;
  logic [WIDTH-1:0] diff_reg;
  logic            borrow_reg;
  logic            bout_reg;
  logic            ovf_reg;
  logic            busy_reg;
  logic            done_reg;

  logic [SLICE-1:0] x_sl [NSLICE];
  logic [SLICE-1:0] y_sl [NSLICE];
  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE-1:0] d_slice;
  logic             slice_bout;

  // View the operands as arrays of slices, and splice the current slice
  // result into the working value so the final edge can load it whole.
  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_slices
      assign x_sl[gi] = x_reg[gi*SLICE +: SLICE];
      assign y_sl[gi] = y_reg[gi*SLICE +: SLICE];
      assign work_next[gi*SLICE +: SLICE] =
        (cnt_reg == CW'(gi)) ? d_slice : work_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  assign a_slice = x_sl[cnt_reg];
  assign b_slice = y_sl[cnt_reg];

  // The single borrow chain, reused every RUN cycle. The running borrow is
  // preloaded with bin on accept, so bin only affects slice 0.
  sub_slice #(.W(SLICE)) u_slice (
    .a   (a_slice),
    .b   (b_slice),
    .bin (borrow_reg),
    .d   (d_slice),
    .bout(slice_bout)
  );

  // Control FSM plus operand, working and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      work_reg   <= '0;
      borrow_reg <= 1'b0;
      diff_reg   <= '0;
      bout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            x_reg      <= x;
            y_reg      <= y;
            borrow_reg <= bin;
            cnt_reg    <= '0;
            state_reg  <= RUN;
            busy_reg   <= 1'b1;
            done_reg   <= 1'b0;
          end else begin
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
          end
        end
        RUN: begin
          work_reg   <= work_next;
          borrow_reg <= slice_bout;
          cnt_reg    <= cnt_reg + CW'(1);
          if (cnt_reg == LAST) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            diff_reg  <= work_next;
            bout_reg  <= slice_bout;
            ovf_reg   <= (x_reg[MSB] != y_reg[MSB]) && (work_next[MSB] != x_reg[MSB]);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign diff = diff_reg;
  assign bout = bout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at 16/4 and 8/2.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;

  logic        start16, bin16, busy16, done16, bout16, ovf16;
  logic [15:0] x16, y16, diff16;
  logic        start8, bin8, busy8, done8, bout8, ovf8;
  logic [7:0]  x8, y8, diff8;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor u16 (
    .clk(clk), .rst(rst), .start(start16), .x(x16), .y(y16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .ovf(ovf16)
  );

  serial_subtractor #(.WIDTH(8), .SLICE(2)) u8 (
    .clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain widened arithmetic, result {ovf, bout, diff}.
  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] t;
    t = {1'b0, a} - {1'b0, b} - {16'd0, c};
    return {((a[15] != b[15]) && (t[15] != a[15])), t[16], t[15:0]};
  endfunction

  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] t;
    t = {1'b0, a} - {1'b0, b} - {8'd0, c};
    return {((a[7] != b[7]) && (t[7] != a[7])), t[8], t[7:0]};
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [7:0] a8, input logic [7:0] b8, input logic c8, input logic s8);
    @(negedge clk);
    x16 = a;  y16 = b;  bin16 = c;  start16 = 1'b1;
    x8  = a8; y8  = b8; bin8  = c8; start8  = s8;
  endtask

  // Counts falling edges until done16 is seen (bounded), and busy cycles on the way.
  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    do begin
      @(negedge clk);
      start16 = 1'b0;
      start8  = 1'b0;
      n++;
      if (busy16) nb++;
    end while (!done16 && n < 20);
  endtask

  task automatic check16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [17:0] r;
    r = model16(a, b, c);
    $display("op16 %s: x=%h y=%h bin=%b -> diff=%h bout=%b ovf=%b (model %h %b %b)",
             tag, a, b, c, diff16, bout16, ovf16, r[15:0], r[16], r[17]);
    chk({tag, "_diff16"}, 32'(diff16), 32'(r[15:0]));
    chk({tag, "_bout16"}, 32'(bout16), 32'(r[16]));
    chk({tag, "_ovf16"},  32'(ovf16),  32'(r[17]));
  endtask

  task automatic check8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [9:0] r;
    r = model8(a, b, c);
    $display("op8  %s: x=%h y=%h bin=%b -> diff=%h bout=%b ovf=%b (model %h %b %b)",
             tag, a, b, c, diff8, bout8, ovf8, r[7:0], r[8], r[9]);
    chk({tag, "_diff8"}, 32'(diff8), 32'(r[7:0]));
    chk({tag, "_bout8"}, 32'(bout8), 32'(r[8]));
    chk({tag, "_ovf8"},  32'(ovf8),  32'(r[9]));
  endtask

  initial begin
    int n, nb, nd;
    logic [15:0] ra, rb;
    logic [7:0]  ra8, rb8;
    logic        rc, rc8;

    rst = 1'b1;
    start16 = 1'b0; x16 = '0; y16 = '0; bin16 = 1'b0;
    start8  = 1'b0; x8  = '0; y8  = '0; bin8  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_done", 32'(done16), 32'd0);
    chk("rst_diff", 32'(diff16), 32'd0);
    chk("rst_bout", 32'(bout16), 32'd0);
    chk("rst_ovf",  32'(ovf16),  32'd0);
    chk("rst_diff8", 32'(diff8), 32'd0);
    rst = 1'b0;

    // Plain subtraction, latency and busy window.
    drive(16'h5555, 16'h1111, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_done(n, nb);
    chk("t1_latency", 32'(n), 32'd5);
    chk("t1_busy_cycles", 32'(nb), 32'd4);
    chk("t1_diff_exact", 32'(diff16), 32'h4444);
    check16("t1", 16'h5555, 16'h1111, 1'b0);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done16), 32'd0);

    // Borrow-in ripples through every slice.
    drive(16'h0000, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1);
    wait_done(n, nb);
    chk("t2_diff_exact", 32'(diff16), 32'hFFFF);
    check16("t2", 16'h0000, 16'h0000, 1'b1);
    check8("t2", 8'h00, 8'h00, 1'b1);

    // Signed overflow, then unsigned underflow.
    drive(16'h8000, 16'h0001, 1'b0, 8'h80, 8'h01, 1'b0, 1'b1);
    wait_done(n, nb);
    chk("t3a_ovf_exact", 32'(ovf16), 32'd1);
    check16("t3a", 16'h8000, 16'h0001, 1'b0);
    check8("t3a", 8'h80, 8'h01, 1'b0);
    drive(16'h0001, 16'h0002, 1'b0, 8'h01, 8'h02, 1'b0, 1'b1);
    wait_done(n, nb);
    chk("t3b_bout_exact", 32'(bout16), 32'd1);
    check16("t3b", 16'h0001, 16'h0002, 1'b0);
    check8("t3b", 8'h01, 8'h02, 1'b0);

    // start during RUN must be ignored.
    drive(16'h1234, 16'h0234, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    x16 = 16'hFFFF; y16 = 16'h0001; bin16 = 1'b1; start16 = 1'b1;
    wait_done(n, nb);
    chk("t4_latency", 32'(n), 32'd3);
    check16("t4", 16'h1234, 16'h0234, 1'b0);

    // Back-to-back: start accepted in the DONE cycle.
    x16 = 16'hA5A5; y16 = 16'h5A5A; bin16 = 1'b0; start16 = 1'b1;
    wait_done(n, nb);
    chk("t5_done_gap", 32'(n), 32'd5);
    check16("t5", 16'hA5A5, 16'h5A5A, 1'b0);

    // Reset in the second RUN cycle.
    drive(16'h0F0F, 16'h0101, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy16), 32'd0);
    chk("t6_rst_done", 32'(done16), 32'd0);
    chk("t6_rst_diff", 32'(diff16), 32'd0);
    chk("t6_rst_bout", 32'(bout16), 32'd0);
    chk("t6_rst_ovf",  32'(ovf16),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done16) nd++;
    end
    chk("t6_no_done", 32'(nd), 32'd0);
    drive(16'h0100, 16'h0001, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_done(n, nb);
    chk("t6_latency", 32'(n), 32'd5);
    chk("t6_diff_exact", 32'(diff16), 32'h00FF);
    check16("t6", 16'h0100, 16'h0001, 1'b0);

    // Random operands on both configurations in lockstep.
    for (int i = 0; i < 1000; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rc  = 1'($urandom);
      ra8 = 8'($urandom);
      rb8 = 8'($urandom);
      rc8 = 1'($urandom);
      drive(ra, rb, rc, ra8, rb8, rc8, 1'b1);
      wait_done(n, nb);
      chk("rnd_latency", 32'(n), 32'd5);
      chk("rnd_done8", 32'(done8), 32'd1);
      check16("rnd", ra, rb, rc);
      check8("rnd", ra8, rb8, rc8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
